// File: rtl/wb_rr_arbiter_if.sv
// Wishbone bundle shared by N_MASTERS masters and one slave port around the
// round-robin arbiter. The slave modport is the arbiter's own view. It is a
// slave to the masters and drives the shared slave port. The master modport
// is the opposite view, used by whatever drives the masters and the slave.
interface wb_arb_if #(
    parameter int N_MASTERS  = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 16
);
    logic [N_MASTERS-1:0]            m_cyc_i;
    logic [N_MASTERS-1:0]            m_stb_i;
    logic [N_MASTERS-1:0]            m_we_i;
    logic [N_MASTERS*ADDR_WIDTH-1:0] m_adr_i;
    logic [N_MASTERS*DATA_WIDTH-1:0] m_dat_i;
    logic [N_MASTERS-1:0]            m_ack_o;
    logic [N_MASTERS-1:0]            m_err_o;
    logic [DATA_WIDTH-1:0]           m_dat_o;
    logic [N_MASTERS-1:0]            gnt_o;
    logic                            s_cyc_o;
    logic                            s_stb_o;
    logic                            s_we_o;
    logic [ADDR_WIDTH-1:0]           s_adr_o;
    logic [DATA_WIDTH-1:0]           s_dat_o;
    logic                            s_ack_i;
    logic [DATA_WIDTH-1:0]           s_dat_i;

    modport slave (
        input  m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, s_ack_i, s_dat_i,
        output m_ack_o, m_err_o, m_dat_o, gnt_o,
               s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o
    );

    modport master (
        output m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, s_ack_i, s_dat_i,
        input  m_ack_o, m_err_o, m_dat_o, gnt_o,
               s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o
    );
endinterface

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone arbiter. It has a registered grant and a
// combinational datapath. The grant is held for a whole cyc assertion. When
// the owner drops cyc, the next master is handed the bus at that same edge.
// Optional watchdog: define WB_ARB_TIMEOUT_EN. It releases and blocks an
// owner whose strobe goes unacknowledged for TIMEOUT_CYCLES cycles. The
// blocked master cannot win again until it drops cyc.
module wb_rr_arbiter #(
    parameter int N_MASTERS      = 2,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 64
) (
    input logic   clk_i,
    input logic   rst_i,
    wb_arb_if.slave bus
);
    localparam int IW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

    typedef enum logic {IDLE, OWNED} state_t;

    state_t               state;
    logic [IW-1:0]        own;
    logic [IW-1:0]        last;
    logic [N_MASTERS-1:0] block;
    logic [N_MASTERS-1:0] gnt_q;
    logic [N_MASTERS-1:0] own_oh;
    logic [N_MASTERS-1:0] req;
    logic [N_MASTERS-1:0] req_arb;
    logic                 timeout;
    logic                 arb_now;
    logic                 found;
    logic [IW-1:0]        winner;

    if (N_MASTERS < 2 || N_MASTERS > 4 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
        $error("wb_rr_arbiter: N_MASTERS must be 2..4 and TIMEOUT_CYCLES >= 2");
    end

    assign own_oh  = {{(N_MASTERS-1){1'b0}}, 1'b1} << own;
    assign req     = bus.m_cyc_i & ~block;
    // A timed-out owner still holds cyc, so it has to be masked out explicitly.
    assign req_arb = timeout ? (req & ~own_oh) : req;
    assign arb_now = (state == IDLE) || !bus.m_cyc_i[own] || timeout;

    // Rotating priority scan that starts just after the previous winner.
    always_comb begin
        int            idx;
        logic [IW-1:0] cand;
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        cand   = '0;
        for (int i = 1; i <= N_MASTERS; i++) begin
            idx  = (int'(last) + i) % N_MASTERS;
            cand = IW'(idx);
            if (!found && req_arb[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    // Arbitration state, grant register and block mask.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
            own   <= '0;
            last  <= IW'(N_MASTERS - 1);
            block <= '0;
            gnt_q <= '0;
        end else begin
            block <= (block & bus.m_cyc_i) | (timeout ? own_oh : '0);
            if (arb_now) begin
                if (found) begin
                    state <= OWNED;
                    own   <= winner;
                    last  <= winner;
                    gnt_q <= {{(N_MASTERS-1){1'b0}}, 1'b1} << winner;
                end else begin
                    state <= IDLE;
                    gnt_q <= '0;
                end
            end
        end
    end

`ifdef WB_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0]        wd_cnt;
    logic [N_MASTERS-1:0] err_q;

    assign timeout = (state == OWNED) && bus.s_stb_o && !bus.s_ack_i &&
                     (wd_cnt == CW'(TIMEOUT_CYCLES - 1));
    assign bus.m_err_o = err_q;

    // Count consecutive unacknowledged strobe cycles of the current owner.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wd_cnt <= '0;
            err_q  <= '0;
        end else begin
            err_q <= timeout ? own_oh : '0;
            if (arb_now || bus.s_ack_i || !bus.s_stb_o) begin
                wd_cnt <= '0;
            end else begin
                wd_cnt <= wd_cnt + 1'b1;
            end
        end
    end
`else
    assign timeout     = 1'b0;
    assign bus.m_err_o = '0;
`endif

    assign bus.gnt_o   = gnt_q;
    assign bus.m_dat_o = bus.s_dat_i;

    // Route the owner's bus to the slave and the slave's ack back to it.
    always_comb begin
        bus.s_cyc_o = 1'b0;
        bus.s_stb_o = 1'b0;
        bus.s_we_o  = 1'b0;
        bus.s_adr_o = '0;
        bus.s_dat_o = '0;
        bus.m_ack_o = '0;
        if (state == OWNED) begin
            bus.s_cyc_o = bus.m_cyc_i[own];
            bus.s_stb_o = bus.m_stb_i[own];
            bus.s_we_o  = bus.m_we_i[own];
            bus.s_adr_o = bus.m_adr_i[own*ADDR_WIDTH +: ADDR_WIDTH];
            bus.s_dat_o = bus.m_dat_i[own*DATA_WIDTH +: DATA_WIDTH];
            bus.m_ack_o = bus.s_ack_i ? own_oh : '0;
        end
    end
endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Bench for wb_rr_arbiter with two masters. A transaction-level model is
// checked against the DUT on every falling edge. Directed scenarios add
// hand-computed literal checks at key points.
module tb_wb_rr_arbiter;
    localparam int N   = 2;
    localparam int AW  = 32;
    localparam int DW  = 16;
    localparam int TMO = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;
    bit   run = 1'b0;

    wb_arb_if #(.N_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    wb_rr_arbiter #(
        .N_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Model state: current owner (-1 = nobody), last winner, blocked masters.
    int       owner = -1;
    int       last_w = N - 1;
    int       stall = 0;
    bit [N-1:0] blocked = '0;
    bit [N-1:0] err_exp = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: one step per rising edge.
    always @(posedge clk) begin
        bit fire;
        int nxt;
        int k;
        fire = 1'b0;
        if (rst) begin
            owner   = -1;
            last_w  = N - 1;
            blocked = '0;
            stall   = 0;
            err_exp = '0;
        end else begin
            err_exp = '0;
            if (owner >= 0 && bus.m_cyc_i[owner]) begin
                if (bus.m_stb_i[owner] && !bus.s_ack_i) stall++;
                else stall = 0;
`ifdef WB_ARB_TIMEOUT_EN
                if (stall == TMO) fire = 1'b1;
`endif
            end
            for (int j = 0; j < N; j++)
                if (!bus.m_cyc_i[j]) blocked[j] = 1'b0;
            if (fire) begin
                blocked[owner] = 1'b1;
                err_exp[owner] = 1'b1;
            end
            if (owner < 0 || !bus.m_cyc_i[owner] || fire) begin
                nxt = -1;
                for (int i = 1; i <= N; i++) begin
                    k = (last_w + i) % N;
                    if (nxt < 0 && bus.m_cyc_i[k] && !blocked[k]) nxt = k;
                end
                owner = nxt;
                if (nxt >= 0) last_w = nxt;
                stall = 0;
            end
        end
    end

    // Compare every DUT output against the model in mid-cycle.
    always @(negedge clk) begin
        logic [N-1:0]  e_gnt;
        logic          e_cyc, e_stb, e_we;
        logic [AW-1:0] e_adr;
        logic [DW-1:0] e_dat;
        if (run) begin
            e_gnt = '0; e_cyc = 1'b0; e_stb = 1'b0; e_we = 1'b0;
            e_adr = '0; e_dat = '0;
            if (owner >= 0) begin
                e_gnt[owner] = 1'b1;
                e_cyc = bus.m_cyc_i[owner];
                e_stb = bus.m_stb_i[owner];
                e_we  = bus.m_we_i[owner];
                e_adr = bus.m_adr_i[owner*AW +: AW];
                e_dat = bus.m_dat_i[owner*DW +: DW];
            end
            chk("gnt_o", bus.gnt_o, e_gnt);
            chk("s_cyc_o", bus.s_cyc_o, e_cyc);
            chk("s_stb_o", bus.s_stb_o, e_stb);
            chk("s_we_o", bus.s_we_o, e_we);
            chk("s_adr_o", bus.s_adr_o, e_adr);
            chk("s_dat_o", bus.s_dat_o, e_dat);
            chk("m_ack_o", bus.m_ack_o, bus.s_ack_i ? e_gnt : '0);
            chk("m_dat_o", bus.m_dat_o, bus.s_dat_i);
            chk("m_err_o", bus.m_err_o, err_exp);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_m(input int k, input logic c, input logic s, input logic w,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.m_cyc_i[k] = c;
        bus.m_stb_i[k] = s;
        bus.m_we_i[k]  = w;
        bus.m_adr_i[k*AW +: AW] = a;
        bus.m_dat_i[k*DW +: DW] = d;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1);
        rst = 1'b0;
    endtask

    initial begin
        bus.m_cyc_i = '0; bus.m_stb_i = '0; bus.m_we_i = '0;
        bus.m_adr_i = '0; bus.m_dat_i = '0;
        bus.s_ack_i = 1'b0; bus.s_dat_i = '0;
        @(posedge clk);
        run = 1'b1;
        step(1);
        rst = 1'b0;
        chk("reset gnt_o", bus.gnt_o, 2'b00);
        chk("reset s_cyc_o", bus.s_cyc_o, 1'b0);

        // Single master write.
        set_m(0, 1, 1, 1, 32'h2, 16'h00C5);
        step(1);
        chk("t1 gnt_o", bus.gnt_o, 2'b01);
        chk("t1 s_adr_o", bus.s_adr_o, 32'h2);
        chk("t1 s_dat_o", bus.s_dat_o, 16'h00C5);
        chk("t1 s_we_o", bus.s_we_o, 1'b1);
        step(1);
        bus.s_ack_i = 1'b1;
        #1;
        chk("t1 m_ack_o", bus.m_ack_o, 2'b01);
        step(1);
        bus.s_ack_i = 1'b0;
        set_m(0, 0, 0, 0, 32'h0, 16'h0);
        step(2);
        chk("t1 idle gnt_o", bus.gnt_o, 2'b00);

        // Simultaneous request after reset, then handoff and a read by master 1.
        do_reset();
        set_m(0, 1, 1, 1, 32'h4, 16'h1234);
        set_m(1, 1, 1, 0, 32'h1, 16'h0);
        step(1);
        chk("t2 first gnt_o", bus.gnt_o, 2'b01);
        bus.s_ack_i = 1'b1;
        step(1);
        bus.s_ack_i = 1'b0;
        set_m(0, 0, 0, 0, 32'h0, 16'h0);
        step(1);
        chk("t2 handoff gnt_o", bus.gnt_o, 2'b10);
        chk("t4 s_adr_o", bus.s_adr_o, 32'h1);
        bus.s_dat_i = 16'h00A5;
        bus.s_ack_i = 1'b1;
        #1;
        chk("t4 m_dat_o", bus.m_dat_o, 16'h00A5);
        chk("t4 m_ack_o", bus.m_ack_o, 2'b10);
        step(1);
        bus.s_ack_i = 1'b0;
        set_m(1, 0, 0, 0, 32'h0, 16'h0);
        step(2);

        // Fairness: both masters keep requesting, so the grant must alternate.
        set_m(0, 1, 1, 1, 32'h10, 16'h0AA0);
        set_m(1, 1, 1, 1, 32'h20, 16'h0BB0);
        step(1);
        for (int i = 0; i < 8; i++) begin
            chk("t3 alternate gnt_o", bus.gnt_o, (i % 2 == 0) ? 2'b01 : 2'b10);
            bus.s_ack_i = 1'b1;
            step(1);
            bus.s_ack_i = 1'b0;
            bus.m_cyc_i[i % 2] = 1'b0;
            bus.m_stb_i[i % 2] = 1'b0;
            step(1);
            bus.m_cyc_i[i % 2] = 1'b1;
            bus.m_stb_i[i % 2] = 1'b1;
        end
        set_m(0, 0, 0, 0, 32'h0, 16'h0);
        set_m(1, 0, 0, 0, 32'h0, 16'h0);
        step(2);

        // Reset while master 0 waits for ack. Without the reset, master 1
        // would win the next contention.
        set_m(0, 1, 1, 1, 32'h8, 16'h5555);
        step(2);
        chk("t5 pre gnt_o", bus.gnt_o, 2'b01);
        rst = 1'b1;
        step(1);
        chk("t5 reset gnt_o", bus.gnt_o, 2'b00);
        chk("t5 reset s_cyc_o", bus.s_cyc_o, 1'b0);
        rst = 1'b0;
        set_m(1, 1, 1, 0, 32'h9, 16'h0);
        step(1);
        chk("t5 regrant gnt_o", bus.gnt_o, 2'b01);
        bus.s_ack_i = 1'b1;
        step(1);
        bus.s_ack_i = 1'b0;
        set_m(0, 0, 0, 0, 32'h0, 16'h0);
        step(1);
        bus.s_ack_i = 1'b1;
        step(1);
        bus.s_ack_i = 1'b0;
        set_m(1, 0, 0, 0, 32'h0, 16'h0);
        step(2);

`ifdef WB_ARB_TIMEOUT_EN
        // Watchdog: master 0 is never acked while master 1 waits.
        do_reset();
        set_m(0, 1, 1, 0, 32'h3, 16'h0);
        step(1);
        set_m(1, 1, 1, 1, 32'h6, 16'h0077);
        step(7);
        chk("t6 before err", bus.m_err_o, 2'b00);
        chk("t6 before gnt", bus.gnt_o, 2'b01);
        step(1);
        chk("t6 err pulse", bus.m_err_o, 2'b01);
        chk("t6 release gnt", bus.gnt_o, 2'b10);
        step(1);
        chk("t6 err cleared", bus.m_err_o, 2'b00);
        bus.s_ack_i = 1'b1;
        step(1);
        bus.s_ack_i = 1'b0;
        set_m(1, 0, 0, 0, 32'h0, 16'h0);
        step(1);
        chk("t6 blocked gnt", bus.gnt_o, 2'b00);
        bus.m_cyc_i[0] = 1'b0;
        bus.m_stb_i[0] = 1'b0;
        step(1);
        bus.m_cyc_i[0] = 1'b1;
        bus.m_stb_i[0] = 1'b1;
        step(1);
        chk("t6 unblocked gnt", bus.gnt_o, 2'b01);
        bus.s_ack_i = 1'b1;
        step(1);
        bus.s_ack_i = 1'b0;
        set_m(0, 0, 0, 0, 32'h0, 16'h0);
        step(2);
`else
        // Without the watchdog, an unacked owner keeps the bus indefinitely.
        do_reset();
        set_m(0, 1, 1, 0, 32'h3, 16'h0);
        step(1);
        set_m(1, 1, 1, 1, 32'h6, 16'h0077);
        step(20);
        chk("t6 hold gnt", bus.gnt_o, 2'b01);
        chk("t6 no err", bus.m_err_o, 2'b00);
        bus.s_ack_i = 1'b1;
        step(1);
        bus.s_ack_i = 1'b0;
        set_m(0, 0, 0, 0, 32'h0, 16'h0);
        step(1);
        chk("t6 handoff gnt", bus.gnt_o, 2'b10);
        bus.s_ack_i = 1'b1;
        step(1);
        bus.s_ack_i = 1'b0;
        set_m(1, 0, 0, 0, 32'h0, 16'h0);
        step(2);
`endif

        run = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
